// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared FSM state type and counter sizing for the bit-serial adder
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: enough to index every bit of the word, never less than one bit
  function automatic int cnt_width(input int w);
    if (w <= 2) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// rtl/bit_serial_adder_full_adder.sv - single combinational full-adder cell shared across all bit steps
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Majority for carry, parity for sum
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - bit-serial adder controller; optional overflow output under BIT_SERIAL_ADDER_OVF_EN
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] in_a,
  input  logic [WORD_WIDTH-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [WORD_WIDTH-1:0] out_s,
  output logic                  out_co,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic                  out_ovf,
`endif
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int CW = cnt_width(WORD_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  state_t                  state;
  logic [WORD_WIDTH-1:0]   a_sh;
  logic [WORD_WIDTH-1:0]   b_sh;
  logic [WORD_WIDTH-1:0]   sum_sh;
  logic                    carry;
  logic [CW-1:0]           cnt;
  logic                    fa_s;
  logic                    fa_co;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic                    c_msb;
`endif

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshake flags come straight from the state register, no path from in_vld/out_rd
  assign in_rd   = (state == IDLE);
  assign out_vld = (state == DONE);
  assign out_s   = sum_sh;
  assign out_co  = carry;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign out_ovf = out_vld & (c_msb ^ carry);
`endif

  // Control FSM with the operand, sum, carry and counter datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      c_msb  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_ci;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WORD_WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WORD_WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WORD_WIDTH-1:1]};
          carry  <= fa_co;
          if (cnt == LAST) begin
            // Counter holds on the final step so it never wraps
`ifdef BIT_SERIAL_ADDER_OVF_EN
            c_msb <= carry;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_rd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
